// File: rtl/iir_out_requant.sv
// Requantising output stage for the first-order IIR filter: shift, saturate, decimate, FIFO.
// Optional round-half-up before the shift is enabled by defining IIR_REQUANT_ROUND_EN.
module iir_out_requant #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 8,
    parameter int SHIFT = 0,
    parameter int DECIM = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [IN_W-1:0]     in_y,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic signed [OUT_W-1:0]    out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       sat_flag,
    output logic                       ovf_flag,
    input  logic                       clr_flags
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DECIM - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic signed [IN_W:0] MAXV = (IN_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [IN_W:0] MINV = (IN_W+1)'(-(2**(OUT_W-1)));

    logic [DW-1:0]           dcnt;
    logic                    accept;
    logic signed [IN_W:0]    y_ext;
    logic signed [IN_W:0]    shifted;
    logic signed [IN_W:0]    s1;
    logic                    s1_valid;
    logic                    clip;
    logic signed [OUT_W-1:0] sat_val;
    logic [OUT_W-1:0]        mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic                    pop;
    logic                    push;
    logic                    drop;

    assign accept = in_valid && (dcnt == '0);
    assign y_ext  = {in_y[IN_W-1], in_y};

`ifdef IIR_REQUANT_ROUND_EN
    // one extra bit of headroom keeps the rounding add from wrapping
    localparam logic signed [IN_W:0] RND = (IN_W+1)'((2**SHIFT) / 2);
    assign shifted = (y_ext + RND) >>> SHIFT;
`else
    assign shifted = y_ext >>> SHIFT;
`endif

    always_comb begin
        clip    = 1'b0;
        sat_val = s1[OUT_W-1:0];
        if (s1 > MAXV) begin
            clip    = 1'b1;
            sat_val = MAXV[OUT_W-1:0];
        end else if (s1 < MINV) begin
            clip    = 1'b1;
            sat_val = MINV[OUT_W-1:0];
        end
    end

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign pop       = out_valid && out_ready;
    assign push      = s1_valid && ((count != FULL) || pop);
    assign drop      = s1_valid && !push;

    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt     <= '0;
            s1       <= '0;
            s1_valid <= 1'b0;
        end else begin
            if (in_valid)
                dcnt <= (dcnt == DLAST) ? '0 : dcnt + 1'b1;
            s1_valid <= accept;
            if (accept)
                s1 <= shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= sat_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // a flag event in the same cycle as clr_flags keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            if (s1_valid && clip)
                sat_flag <= 1'b1;
            else if (clr_flags)
                sat_flag <= 1'b0;
            if (drop)
                ovf_flag <= 1'b1;
            else if (clr_flags)
                ovf_flag <= 1'b0;
        end
    end
endmodule

// File: tb/tb_iir_out_requant.sv
// Directed self-checking bench for iir_out_requant: default, DECIM=3 and SHIFT=2 instances.
module tb_iir_out_requant;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    int checks = 0;
    int errors = 0;

    logic              a_iv = 1'b0, a_rdy = 1'b0;
    logic signed [16:0] a_y = '0;
    logic              a_ov, a_sat, a_ovf;
    logic signed [7:0] a_d;
    logic [2:0]        a_cnt;

    logic              d_iv = 1'b0, d_rdy = 1'b0;
    logic signed [16:0] d_y = '0;
    logic              d_ov, d_sat, d_ovf;
    logic signed [7:0] d_d;
    logic [2:0]        d_cnt;

    logic              s_iv = 1'b0, s_rdy = 1'b0;
    logic signed [16:0] s_y = '0;
    logic              s_ov, s_sat, s_ovf;
    logic signed [7:0] s_d;
    logic [2:0]        s_cnt;

    always #5 clk = ~clk;

    iir_out_requant u_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_y(a_y),
        .out_ready(a_rdy), .out_valid(a_ov), .out_data(a_d),
        .count(a_cnt), .sat_flag(a_sat), .ovf_flag(a_ovf),
        .clr_flags(clr)
    );

    iir_out_requant #(.DECIM(3)) u_d (
        .clk(clk), .rst(rst), .in_valid(d_iv), .in_y(d_y),
        .out_ready(d_rdy), .out_valid(d_ov), .out_data(d_d),
        .count(d_cnt), .sat_flag(d_sat), .ovf_flag(d_ovf),
        .clr_flags(clr)
    );

    iir_out_requant #(.SHIFT(2)) u_s (
        .clk(clk), .rst(rst), .in_valid(s_iv), .in_y(s_y),
        .out_ready(s_rdy), .out_valid(s_ov), .out_data(s_d),
        .count(s_cnt), .sat_flag(s_sat), .ovf_flag(s_ovf),
        .clr_flags(clr)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        checks++;
        if ({a_ov, a_d, a_cnt, a_sat, a_ovf} !== 14'd0) begin
            errors++;
            $display("FAIL reset_idle: got ov=%b d=%0d cnt=%0d sat=%b ovf=%b, want all 0",
                     a_ov, a_d, a_cnt, a_sat, a_ovf);
        end
        a_rdy = 1'b0;
        a_iv = 1'b1; a_y = 17'sd7; tick();
        a_y = 17'sd8; tick();
        a_iv = 1'b0; tick(2);
        checks++;
        if (a_cnt !== 3'd2) begin
            errors++;
            $display("FAIL reset_prefill_count: got %0d want 2", a_cnt);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (a_cnt !== 3'd0 || a_ov !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop: got cnt=%0d ov=%b want 0 0", a_cnt, a_ov);
        end
    endtask

    task automatic test_single;
        a_rdy = 1'b1;
        a_iv = 1'b1; a_y = 17'sd100; tick();
        a_iv = 1'b0;
        checks++;
        if (a_ov !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: got ov=%b want 0 after accept edge", a_ov);
        end
        tick();
        checks++;
        if (a_ov !== 1'b1 || a_d !== 8'sd100) begin
            errors++;
            $display("FAIL single_out: got ov=%b d=%0d want 1 100", a_ov, a_d);
        end
        tick();
        checks++;
        if (a_ov !== 1'b0 || a_d !== 8'sd0) begin
            errors++;
            $display("FAIL single_pop: got ov=%b d=%0d want 0 0", a_ov, a_d);
        end
    endtask

    task automatic test_saturation;
        int ins[3]  = '{300, -200, 5};
        int outs[3] = '{127, -128, 5};
        a_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_iv = 1'b1; a_y = 17'(ins[i]); tick();
        end
        a_iv = 1'b0; tick(2);
        a_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (a_ov !== 1'b1 || int'(a_d) !== outs[i]) begin
                errors++;
                $display("FAIL sat_out[%0d]: got ov=%b d=%0d want 1 %0d", i, a_ov, a_d, outs[i]);
            end
            tick();
        end
        checks++;
        if (a_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_flag_set: got %b want 1", a_sat);
        end
        clr = 1'b1; tick(); clr = 1'b0;
        checks++;
        if (a_sat !== 1'b0) begin
            errors++;
            $display("FAIL sat_flag_clr: got %b want 0", a_sat);
        end
        a_iv = 1'b1; a_y = 17'sd400; tick();
        a_iv = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
        checks++;
        if (a_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_clr_collide: got %b want 1", a_sat);
        end
        tick(2);
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    task automatic test_overflow;
        a_rdy = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            a_iv = 1'b1; a_y = 17'(i); tick();
        end
        a_iv = 1'b0; tick(2);
        checks++;
        if (a_cnt !== 3'd4 || a_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_full: got cnt=%0d ovf=%b want 4 1", a_cnt, a_ovf);
        end
        a_rdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (a_ov !== 1'b1 || int'(a_d) !== i) begin
                errors++;
                $display("FAIL ovf_drain[%0d]: got ov=%b d=%0d want 1 %0d", i, a_ov, a_d, i);
            end
            tick();
        end
        checks++;
        if (a_ov !== 1'b0 || a_cnt !== 3'd0) begin
            errors++;
            $display("FAIL ovf_empty: got ov=%b cnt=%0d want 0 0", a_ov, a_cnt);
        end
        clr = 1'b1; tick(); clr = 1'b0;
        a_rdy = 1'b0;
        for (int i = 10; i <= 13; i++) begin
            a_iv = 1'b1; a_y = 17'(i); tick();
        end
        a_y = 17'sd14; tick();
        a_iv = 1'b0; a_rdy = 1'b1;
        checks++;
        if (a_cnt !== 3'd4 || a_d !== 8'sd10) begin
            errors++;
            $display("FAIL full_pp_pre: got cnt=%0d d=%0d want 4 10", a_cnt, a_d);
        end
        tick();
        a_rdy = 1'b0;
        checks++;
        if (a_cnt !== 3'd4 || a_ovf !== 1'b0 || a_d !== 8'sd11) begin
            errors++;
            $display("FAIL full_pp: got cnt=%0d ovf=%b d=%0d want 4 0 11", a_cnt, a_ovf, a_d);
        end
        a_rdy = 1'b1;
        for (int i = 11; i <= 14; i++) begin
            checks++;
            if (int'(a_d) !== i) begin
                errors++;
                $display("FAIL full_pp_drain: got %0d want %0d", a_d, i);
            end
            tick();
        end
    endtask

    task automatic test_decim;
        int exp_d[3] = '{10, 13, 16};
        rst = 1'b1; tick(); rst = 1'b0;
        d_rdy = 1'b0;
        for (int i = 10; i <= 16; i++) begin
            d_iv = 1'b1; d_y = 17'(i); tick();
        end
        d_iv = 1'b0; tick(2);
        checks++;
        if (d_cnt !== 3'd3) begin
            errors++;
            $display("FAIL decim_count: got %0d want 3", d_cnt);
        end
        d_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (d_ov !== 1'b1 || int'(d_d) !== exp_d[i]) begin
                errors++;
                $display("FAIL decim_out[%0d]: got ov=%b d=%0d want 1 %0d", i, d_ov, d_d, exp_d[i]);
            end
            tick();
        end
    endtask

    task automatic test_shift;
`ifdef IIR_REQUANT_ROUND_EN
        int exp_s[2] = '{2, -1};
`else
        int exp_s[2] = '{1, -2};
`endif
        s_rdy = 1'b0;
        s_iv = 1'b1; s_y = 17'sd6; tick();
        s_y = -17'sd6; tick();
        s_iv = 1'b0; tick(2);
        s_rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (s_ov !== 1'b1 || int'(s_d) !== exp_s[i]) begin
                errors++;
                $display("FAIL shift_out[%0d]: got ov=%b d=%0d want 1 %0d", i, s_ov, s_d, exp_s[i]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_overflow();
        test_decim();
        test_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
